// File: rtl/cache_controller_pkg.sv
// Shared widths, default data-memory base and FSM encoding for the cache controller.
package cache_controller_pkg;

  localparam int unsigned WORD_LEN       = 32;
  localparam int unsigned BLOCK_LEN      = 64;
  localparam int unsigned CACHE_ADDR_LEN = 17;

  localparam logic [WORD_LEN-1:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SRAM_READ  = 2'd1,
    SRAM_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/mux2to1.sv
// Generic 2:1 word multiplexer; picks the even or odd word of a fetched block.
module mux2to1 #(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic                sel,
  input  logic [WORD_LEN-1:0] in0,
  input  logic [WORD_LEN-1:0] in1,
  output logic [WORD_LEN-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-allocate-on-store controller between the MEM stage, a direct-mapped
// cache and a block-wide SRAM. Read hits complete in the same cycle.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter logic [WORD_LEN-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_LEN-1:0]       address,
  input  logic [WORD_LEN-1:0]       wdata,
  input  logic                      MEM_R_EN,
  input  logic                      MEM_W_EN,
  output logic [WORD_LEN-1:0]       rdata,
  output logic                      ready,
  output logic [CACHE_ADDR_LEN-1:0] cache_address,
  output logic [BLOCK_LEN-1:0]      cache_write_data,
  output logic                      cache_read_en,
  output logic                      cache_write_en,
  output logic                      invalidate,
  input  logic [WORD_LEN-1:0]       cache_read_data,
  input  logic                      cache_hit,
  output logic [WORD_LEN-1:0]       sram_address,
  output logic [WORD_LEN-1:0]       sram_wdata,
  output logic                      sram_read_en,
  output logic                      sram_write_en,
  input  logic [BLOCK_LEN-1:0]      sram_rdata,
  input  logic                      sram_ready
);

  state_t                    state_q;
  logic [WORD_LEN-1:0]       addr_q;
  logic [WORD_LEN-1:0]       wdata_q;
  logic [WORD_LEN-1:0]       fill_word;
  logic [CACHE_ADDR_LEN-1:0] live_idx;
  logic [CACHE_ADDR_LEN-1:0] lat_idx;
  logic                      st_req;
  logic                      rd_req;

  // Word index into the cache: byte offset from the data-memory base, modulo 2^32.
  assign live_idx = CACHE_ADDR_LEN'((address - BASE_ADDR) >> 2);
  assign lat_idx  = CACHE_ADDR_LEN'((addr_q - BASE_ADDR) >> 2);

  // A simultaneous load and store is handled as a store.
  assign st_req = MEM_W_EN;
  assign rd_req = MEM_R_EN & ~MEM_W_EN;

  assign cache_address = (state_q == IDLE) ? live_idx : lat_idx;

  mux2to1 #(
    .WORD_LEN(WORD_LEN)
  ) u_word_mux (
    .sel(lat_idx[0]),
    .in0(sram_rdata[WORD_LEN-1:0]),
    .in1(sram_rdata[BLOCK_LEN-1:WORD_LEN]),
    .out(fill_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (st_req) begin
            addr_q  <= address;
            wdata_q <= wdata;
            state_q <= SRAM_WRITE;
          end else if (rd_req && !cache_hit) begin
            addr_q  <= address;
            state_q <= SRAM_READ;
          end
        end
        SRAM_READ: begin
          if (sram_ready) state_q <= IDLE;
        end
        SRAM_WRITE: begin
          if (sram_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready            = 1'b1;
    rdata            = '0;
    cache_write_data = '0;
    cache_read_en    = 1'b0;
    cache_write_en   = 1'b0;
    invalidate       = 1'b0;
    sram_address     = '0;
    sram_wdata       = '0;
    sram_read_en     = 1'b0;
    sram_write_en    = 1'b0;
    // Outputs stay at their idle values for as long as reset is held.
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (st_req) begin
            invalidate = cache_hit;
            ready      = 1'b0;
          end else if (rd_req) begin
            if (cache_hit) begin
              cache_read_en = 1'b1;
              rdata         = cache_read_data;
            end else begin
              ready = 1'b0;
            end
          end
        end
        SRAM_READ: begin
          sram_read_en = 1'b1;
          sram_address = addr_q;
          ready        = sram_ready;
          if (sram_ready) begin
            cache_write_en   = 1'b1;
            cache_write_data = sram_rdata;
            rdata            = fill_word;
          end
        end
        SRAM_WRITE: begin
          sram_write_en = 1'b1;
          sram_address  = addr_q;
          sram_wdata    = wdata_q;
          ready         = sram_ready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller against a transaction-level model.
module tb_cache_controller;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata, rdata, cache_read_data, sram_address, sram_wdata;
  logic        MEM_R_EN, MEM_W_EN, ready, cache_read_en, cache_write_en, invalidate;
  logic        cache_hit, sram_read_en, sram_write_en, sram_ready;
  logic [16:0] cache_address;
  logic [63:0] cache_write_data, sram_rdata;

  cache_controller #(
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .wdata(wdata),
    .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN),
    .rdata(rdata),
    .ready(ready),
    .cache_address(cache_address),
    .cache_write_data(cache_write_data),
    .cache_read_en(cache_read_en),
    .cache_write_en(cache_write_en),
    .invalidate(invalidate),
    .cache_read_data(cache_read_data),
    .cache_hit(cache_hit),
    .sram_address(sram_address),
    .sram_wdata(sram_wdata),
    .sram_read_en(sram_read_en),
    .sram_write_en(sram_write_en),
    .sram_rdata(sram_rdata),
    .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_store;
    bit          is_miss;
    bit          inval;
    bit          cre;
    int          wait_cycles;
    logic [31:0] rdata;
    logic [16:0] caddr;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [63:0] fill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Model: cache index is the word number of (addr - BASE) modulo 2^32; bit 0 selects the word.
  function automatic logic [16:0] model_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 17'((off / 4) % 32'h20000);
  endfunction

  // op: 0 idle, 1 load, 2 store, 3 load+store. lat = cycles spent in the SRAM state.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] wd, input bit hit,
                       input logic [31:0] crd, input int lat, input logic [63:0] fill,
                       input bit spur);
    exp_t e;
    bit   st, miss;
    st   = (op == 2) || (op == 3);
    miss = (op == 1) && !hit;
    address         = a;
    wdata           = wd;
    MEM_R_EN        = (op == 1) || (op == 3);
    MEM_W_EN        = st;
    cache_hit       = hit;
    cache_read_data = crd;
    sram_ready      = (op == 0) ? spur : 1'b0;
    sram_rdata      = {$urandom, $urandom};
    if (op != 0) begin
      e.is_store    = st;
      e.is_miss     = miss;
      e.inval       = st && hit;
      e.cre         = (op == 1) && hit;
      e.wait_cycles = (st || miss) ? lat : 0;
      e.caddr       = model_idx(a);
      e.saddr       = a;
      e.swdata      = wd;
      e.fill        = fill;
      if (miss) e.rdata = (model_idx(a) % 2 == 1) ? fill[63:32] : fill[31:0];
      else      e.rdata = crd;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    if (st || miss) begin
      for (int k = 1; k <= lat; k++) begin
        // In-flight operation must not follow the live MEM-stage inputs.
        address         = $urandom;
        wdata           = $urandom;
        cache_hit       = 1'($urandom);
        cache_read_data = $urandom;
        sram_ready      = (k == lat);
        sram_rdata      = (k == lat) ? fill : {$urandom, $urandom};
        @(posedge clk); #1;
      end
    end
  endtask

  // Monitor: accumulates per-transaction observations and checks when ready closes one.
  initial begin
    exp_t e;
    int low_cnt, rd_cnt, wr_cnt, inv_cnt, cwe_cnt, cre_cnt;
    low_cnt = 0; rd_cnt = 0; wr_cnt = 0; inv_cnt = 0; cwe_cnt = 0; cre_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst) begin
        low_cnt = 0; rd_cnt = 0; wr_cnt = 0; inv_cnt = 0; cwe_cnt = 0; cre_cnt = 0;
      end else if (MEM_R_EN || MEM_W_EN) begin
        if (sb_q.size() == 0) begin
          if (ready) flag("sb_unexpected_ready");
        end else begin
          e = sb_q[0];
          if (!ready) low_cnt++;
          if (sram_read_en) begin
            rd_cnt++;
            chk("sram_rd_address", sram_address, e.saddr);
          end
          if (sram_write_en) begin
            wr_cnt++;
            chk("sram_wr_address", sram_address, e.saddr);
            chk("sram_wdata", sram_wdata, e.swdata);
          end
          chk("rw_exclusive", 64'(sram_read_en & sram_write_en), 0);
          inv_cnt += int'(invalidate);
          cwe_cnt += int'(cache_write_en);
          cre_cnt += int'(cache_read_en);
          if (low_cnt > 20) begin
            flag("ready_timeout");
            void'(sb_q.pop_front());
            low_cnt = 0; rd_cnt = 0; wr_cnt = 0; inv_cnt = 0; cwe_cnt = 0; cre_cnt = 0;
          end else if (ready) begin
            void'(sb_q.pop_front());
            chk("wait_cycles", low_cnt, e.wait_cycles);
            chk("invalidate_cycles", inv_cnt, 64'(e.inval));
            chk("cache_read_en_cycles", cre_cnt, 64'(e.cre));
            chk("cache_write_en_cycles", cwe_cnt, 64'(e.is_miss));
            chk("sram_read_cycles", rd_cnt, e.is_miss ? e.wait_cycles : 0);
            chk("sram_write_cycles", wr_cnt, e.is_store ? e.wait_cycles : 0);
            if (!e.is_store) begin
              chk("rdata", rdata, e.rdata);
              chk("cache_address", cache_address, e.caddr);
            end
            if (e.is_miss) chk("cache_write_data", cache_write_data, e.fill);
            low_cnt = 0; rd_cnt = 0; wr_cnt = 0; inv_cnt = 0; cwe_cnt = 0; cre_cnt = 0;
          end
        end
      end else begin
        chk("idle_ready", ready, 1);
        chk("idle_strobes", {cache_read_en, cache_write_en, invalidate, sram_read_en,
                             sram_write_en}, 0);
        chk("idle_rdata", rdata, 0);
        chk("idle_sram_address", sram_address, 0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_strobes"}, {cache_read_en, cache_write_en, invalidate, sram_read_en,
                            sram_write_en}, 0);
    chk({tag, "_sram_address"}, sram_address, 0);
    chk({tag, "_sram_wdata"}, sram_wdata, 0);
    chk({tag, "_cache_write_data"}, cache_write_data, 0);
  endtask

  initial begin
    int          op, kind, lat;
    logic [31:0] a;
    rst = 1'b0; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    cache_hit = 1'b0; cache_read_data = '0; sram_ready = 1'b1;
    sram_rdata = 64'hFFFF_0000_FFFF_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b1; sram_ready = 1'b0;
    mon_en = 1'b1;

    // Directed scenarios.
    issue(1, 32'h408, 32'h0, 1'b0, 32'h0, 4, 64'hAAAA_BBBB_1111_2222, 1'b0);
    issue(1, 32'h40C, 32'h0, 1'b1, 32'hDEAD_BEEF, 0, 64'h0, 1'b0);
    issue(2, 32'h400, 32'h5, 1'b1, 32'h0, 3, 64'h0, 1'b0);
    issue(3, 32'h410, 32'h1234_5678, 1'b0, 32'h0, 2, 64'h0, 1'b0);
    issue(0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 64'h0, 1'b1);
    issue(1, 32'h40C, 32'h0, 1'b0, 32'h0, 1, 64'h0123_4567_89AB_CDEF, 1'b0);
    issue(1, 32'h0000_0004, 32'h0, 1'b0, 32'h0, 2, 64'h5555_6666_7777_8888, 1'b0);

    // Reset two cycles into a read miss.
    issue(0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 64'h0, 1'b0);
    mon_en = 1'b0;
    address = 32'h420; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; cache_hit = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_read_sram_address", sram_address, 32'h420);
    @(posedge clk); #1;
    rst = 1'b0; cache_hit = 1'b1; sram_ready = 1'b1; sram_rdata = 64'hCAFE_F00D_BAAD_F00D;
    @(negedge clk);
    chk_reset_outputs("rst_held");
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("rst_held2");
    @(posedge clk); #1;
    rst = 1'b1; MEM_R_EN = 1'b0; cache_hit = 1'b0; sram_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_sram_read_en", sram_read_en, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) op = 0;
      else if (kind < 7) op = 1;
      else if (kind < 9) op = 2;
      else op = 3;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + $urandom_range(0, 32'h000F_FFFF);
      lat = $urandom_range(1, 5);
      issue(op, a, $urandom, (kind == 5 || kind == 6) ? 1'b0 : 1'($urandom), $urandom, lat,
            {$urandom, $urandom}, 1'($urandom));
    end

    repeat (3) issue(0, 32'h0, 32'h0, 1'b0, 32'h0, 0, 64'h0, 1'b0);
    @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-002 Parameter BASE_ADDR, default 32'd1024, data-memory byte base subtracted before cache indexing.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 address  in  32  MEM-stage byte address.
REQ-006 wdata  in  32  MEM-stage store data.
REQ-007 MEM_R_EN / MEM_W_EN  in  1 each  load / store request.
REQ-008 rdata  out  32  load result.
REQ-009 ready  out  1  request complete; low freezes the pipeline.
REQ-010 cache_address  out  17  {tag[9:0], row[5:0], col}.
REQ-011 cache_write_data  out  64  block fill data.
REQ-012 cache_read_en / cache_write_en / invalidate  out  1 each  cache controls.
REQ-013 cache_read_data  in  32; cache_hit  in  1.
REQ-014 sram_address  out  32; sram_wdata  out  32; sram_read_en / sram_write_en  out  1 each.
REQ-015 sram_rdata  in  64  block (two words, bits [63:32] = odd word); sram_ready  in  1  one-cycle completion pulse.

Function
REQ-016 cache_address SHALL equal (address - BASE_ADDR)[18:2], combinational from the live address in IDLE, from the latched address otherwise.
REQ-017 FSM states SHALL be IDLE, SRAM_READ, SRAM_WRITE.
REQ-018 IDLE, no request: ready=1, all cache/SRAM strobes 0.
REQ-019 IDLE, MEM_R_EN and cache_hit: cache_read_en=1, rdata=cache_read_data, ready=1 same cycle (zero-wait hit), stay IDLE.
REQ-020 IDLE, MEM_R_EN and no hit: ready=0, latch address, next state SRAM_READ.
REQ-021 SRAM_READ: sram_read_en=1, sram_address=latched address, ready=0 until sram_ready.
REQ-022 SRAM_READ with sram_ready: cache_write_en=1, cache_write_data=sram_rdata, rdata=latched col ? sram_rdata[63:32] : sram_rdata[31:0], ready=1, next IDLE.
REQ-023 IDLE, MEM_W_EN: write-through, no-allocate; invalidate=cache_hit in that cycle only; latch address and wdata; ready=0; next SRAM_WRITE.
REQ-024 SRAM_WRITE: sram_write_en=1, sram_wdata=latched wdata; on sram_ready ready=1, next IDLE; cache_write_en never asserted for stores.
REQ-025 MEM_R_EN and MEM_W_EN both high SHALL be treated as a store.
REQ-026 sram_ready while in IDLE SHALL be ignored.
REQ-027 sram_read_en and sram_write_en SHALL never be high together.
REQ-028 Address arithmetic SHALL be 32-bit unsigned; addresses below BASE_ADDR wrap modulo 2^32 without error.
REQ-029 MEM inputs changing while ready=0 SHALL not affect the operation in flight.

Reset
REQ-030 rst low at a clock edge SHALL force IDLE and clear latched address/wdata, including mid-transaction (pending SRAM request dropped).
REQ-031 While reset is held: ready=1, rdata=0, all strobes 0, sram_address=0, sram_wdata=0, cache_write_data=0.

Structure
REQ-032 State encodings, BASE_ADDR default, and widths (WORD_LEN=32, BLOCK_LEN=64, CACHE_ADDR_LEN=17) SHALL live in the shared defines package.
REQ-033 Miss-path word select SHALL instantiate the existing 2:1 word mux (mux2to1, WORD_LEN=32); no other sub-module.

Verification
REQ-034 Read miss: MEM_R_EN, address=0x408, hit=0; sram_ready after 4 cycles with sram_rdata=0xAAAA_BBBB_1111_2222 -> ready low 4 cycles, then rdata=0x1111_2222, cache_write_en one cycle, cache_address=0x00002.
REQ-035 Read hit: address=0x40C, hit=1, cache_read_data=0xDEADBEEF -> same-cycle ready=1, rdata=0xDEADBEEF, no SRAM strobe.
REQ-036 Store hit: MEM_W_EN, address=0x400, wdata=0x5, hit=1 -> invalidate one cycle, sram_write_en until sram_ready, sram_wdata=0x5, cache_write_en never high.
REQ-037 Reset mid-read: rst low two cycles into SRAM_READ -> next cycle IDLE, sram_read_en=0, ready=1.
REQ-038 Simultaneous R/W at 0x410 -> store path taken, sram_read_en never high.
REQ-039 Spurious sram_ready in IDLE with no request -> no output change.
